// File: rtl/pipelined_tmr_adder_if.sv
// Purpose: operand/result bundle for pipelined_tmr_adder.
// Latency: n/a, wires only.
// Backpressure: none; the master may present a transaction on any cycle.
interface pipelined_tmr_adder_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       inj_mask;
  logic             out_valid;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             fault;
  logic [CNT_W-1:0] fault_count;

  modport master (
    output in_valid, a, b, cin, inj_mask,
    input  out_valid, s, cout, fault, fault_count
  );

  modport slave (
    input  in_valid, a, b, cin, inj_mask,
    output out_valid, s, cout, fault, fault_count
  );
endinterface

// File: rtl/pipelined_tmr_adder.sv
// Purpose: chunked carry-pipelined adder, optionally three voted copies with fault flag/count.
// Latency: STAGES+1 cycles (input capture + STAGES add stages feed the registered voter).
// Backpressure: none; one transaction per cycle, bubbles pass through as out_valid=0.
module pipelined_tmr_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int TMR    = 1,
  parameter int CNT_W  = 8
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_tmr_adder_if.slave bus
);
  localparam int C  = WIDTH / STAGES;
  localparam int NC = (TMR != 0) ? 3 : 1;

  logic [WIDTH-1:0] w_cp_sum [NC];
  logic [NC-1:0]    w_cp_cout;
  logic [NC-1:0]    w_cp_vld;

  for (genvar g = 0; g < NC; g++) begin : g_copy
    // r_a/r_b[j] feed stage j; operands shift down one chunk per stage so the
    // chunk a stage needs always sits in the low C bits.
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    // Sum chunks enter at the top and shift down; after STAGES shifts every
    // chunk lands in its own bit position.
    logic [WIDTH-1:0] r_sum [STAGES+1];
    logic [STAGES:0]  r_c;
    logic [STAGES:0]  r_v;
    logic             r_inj;
    logic [C:0]       w_add [STAGES];
    logic [C-1:0]     w_res [STAGES];

    // Per-stage chunk add; injection flips only the chunk-0 sum bit, never its carry.
    always_comb begin
      for (int j = 0; j < STAGES; j++) begin
        w_add[j] = {1'b0, r_a[j][C-1:0]} + {1'b0, r_b[j][C-1:0]} + {{C{1'b0}}, r_c[j]};
        w_res[j] = w_add[j][C-1:0] ^ ((j == 0) ? C'(r_inj) : {C{1'b0}});
      end
    end

    // Input capture, operand skew and sum deskew registers for this copy.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < STAGES; j++) begin
          r_a[j] <= '0;
          r_b[j] <= '0;
        end
        for (int j = 0; j <= STAGES; j++) begin
          r_sum[j] <= '0;
        end
        r_c   <= '0;
        r_v   <= '0;
        r_inj <= 1'b0;
      end else begin
        r_v[0]   <= bus.in_valid;
        r_a[0]   <= bus.a;
        r_b[0]   <= bus.b;
        r_c[0]   <= bus.cin;
        r_inj    <= bus.in_valid & bus.inj_mask[g];
        r_sum[0] <= '0;
        for (int j = 1; j < STAGES; j++) begin
          r_a[j] <= r_a[j-1] >> C;
          r_b[j] <= r_b[j-1] >> C;
        end
        for (int j = 0; j < STAGES; j++) begin
          r_v[j+1]   <= r_v[j];
          r_c[j+1]   <= w_add[j][C];
          r_sum[j+1] <= WIDTH'({w_res[j], r_sum[j]} >> C);
        end
      end
    end

    assign w_cp_sum[g]  = r_sum[STAGES];
    assign w_cp_cout[g] = r_c[STAGES];
    assign w_cp_vld[g]  = r_v[STAGES];
  end

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_vld;
  logic             w_fault;

  if (TMR != 0) begin : g_vote
    // Bitwise majority; any copy disagreeing with the vote raises fault.
    always_comb begin
      w_sum   = (w_cp_sum[0] & w_cp_sum[1]) | (w_cp_sum[0] & w_cp_sum[2]) |
                (w_cp_sum[1] & w_cp_sum[2]);
      w_cout  = (w_cp_cout[0] & w_cp_cout[1]) | (w_cp_cout[0] & w_cp_cout[2]) |
                (w_cp_cout[1] & w_cp_cout[2]);
      w_vld   = (w_cp_vld[0] & w_cp_vld[1]) | (w_cp_vld[0] & w_cp_vld[2]) |
                (w_cp_vld[1] & w_cp_vld[2]);
      w_fault = w_vld & (({w_cp_cout[0], w_cp_sum[0]} != {w_cout, w_sum}) |
                         ({w_cp_cout[1], w_cp_sum[1]} != {w_cout, w_sum}) |
                         ({w_cp_cout[2], w_cp_sum[2]} != {w_cout, w_sum}));
    end
  end else begin : g_single
    // Single copy passes straight through; nothing to compare against.
    always_comb begin
      w_sum   = w_cp_sum[0];
      w_cout  = w_cp_cout[0];
      w_vld   = w_cp_vld[0];
      w_fault = 1'b0;
    end
  end

  logic             r_out_vld;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_fault;
  logic [CNT_W-1:0] r_cnt;

  // Output stage: hold last valid result, pulse fault, saturating fault count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_s       <= '0;
      r_cout    <= 1'b0;
      r_fault   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_out_vld <= w_vld;
      r_fault   <= w_fault;
      if (w_vld) begin
        r_s    <= w_sum;
        r_cout <= w_cout;
      end
      if (w_fault && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.out_valid   = r_out_vld;
  assign bus.s           = r_s;
  assign bus.cout        = r_cout;
  assign bus.fault       = r_fault;
  assign bus.fault_count = r_cnt;
endmodule

// File: doc/pipelined_tmr_adder.md
# pipelined_tmr_adder

Parametrised, pipelined, optionally triplicated adder: the next generation of the team's registered 64-bit adder. Operands are split into STAGES equal chunks with the carry rippled through pipeline registers, which sustains one addition per cycle at wide WIDTH. With TMR=1 three independent pipeline copies are majority-voted per bit, and disagreements are flagged and counted. A per-copy fault-injection input lets the lab exercise the voter.

## Interface
- WIDTH, 64, operand/sum width; must be a multiple of STAGES
- STAGES, 4, number of add stages; chunk width C = WIDTH/STAGES; 1 ≤ STAGES ≤ WIDTH
- TMR, 1, 1 = three voted copies; 0 = single copy, no voter
- CNT_W, 8, width of fault_count
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  a/b/cin qualify this cycle
- a, b  input  WIDTH  operands
- cin  input  1  carry in
- inj_mask  input  3  bit k set with in_valid inverts bit 0 of copy k's chunk-0 sum for that transaction (copy 0 only when TMR=0)
- out_valid  output  1  s/cout/fault qualify this cycle
- s  output  WIDTH  voted sum
- cout  output  1  voted carry out
- fault  output  1  one-cycle pulse with out_valid when any copy differs from the vote
- fault_count  output  CNT_W  saturating count of faulted results

## Operation
- No stall, no backpressure; one transaction accepted per cycle; bubbles (in_valid=0) propagate as out_valid=0.
- Per copy, stage k (0..STAGES-1) adds chunk k of a and b (bits k*C+C-1 : k*C) plus carry from stage k-1 (cin for k=0), producing C sum bits and a carry, both registered.
- Upper-chunk operands travel through skew registers so chunk k enters its adder exactly k cycles after capture; lower sum chunks travel through deskew registers so all chunks align at the last stage.
- Injection: the inverted bit affects only the sum bit, not the chunk-0 carry; inj_mask is ignored when in_valid=0.
- Voter (TMR=1): s[i] = maj(s0[i],s1[i],s2[i]); cout likewise; fault = (any copy's {cout,sum} ≠ voted {cout,s}) & valid.
- TMR=0: s/cout from copy 0; fault and fault_count held 0.
- fault_count increments by 1 on each fault pulse and saturates at 2^CNT_W−1.
- s/cout hold the last valid result while out_valid=0.
- Arithmetic: {cout,s} = a + b + cin modulo 2^(WIDTH+1), exact.

## Timing
- Latency: STAGES+1 cycles; a transaction with in_valid at edge n has out_valid=1 on the cycle after edge n+STAGES+1 (STAGES add stages plus one registered voter/output stage).
- Throughput: 1 result/cycle; back-to-back transactions never interfere.
- Reset: all valid bits, s, cout, fault, fault_count, and pipeline data cleared to 0 on the first edge with rst=1; in_valid during rst is dropped.
- Reset mid-operation: all in-flight transactions are discarded; no out_valid for them after rst deasserts; the first post-reset input emerges after the full latency.
- rst and a saturating increment in the same cycle: reset wins (count = 0).

## Test plan
- Carry ripple across all chunks: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> after 5 cycles s=0, cout=1, fault=0.
- Streaming: 100 back-to-back random operand pairs, with in_valid bubbles every 7th cycle -> each result equals a+b+cin in order; out_valid pattern equals in_valid delayed 5 cycles.
- Single-copy injection: a=5, b=3, cin=0, inj_mask=3'b010 -> s=8, cout=0, fault pulses once, fault_count 0→1.
- Double-copy injection: same operands, inj_mask=3'b011 -> s=9 (corrupted majority), fault=1 since copy 2 differs; documents the TMR limit.
- Saturation with CNT_W=2: 5 injected transactions -> fault_count 1,2,3,3,3.
- Reset mid-flight: 3 transactions issued, rst asserted 2 cycles later for 1 cycle -> no out_valid for them; all outputs 0; next input a=1, b=1 yields s=2 after 5 cycles.
